reg_dump_unit: RTL and testbench
================================

REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

Interface
REQ-001 Parameter NUM_REGS, default 32: number of register-file entries walked.
REQ-002 Parameter ADDR_WIDTH, default 5: register index width.
REQ-003 Parameter DATA_WIDTH, default 32: register data width.
REQ-004 Parameter SKIP_ZERO, default 1: when 1, index 0 is not dumped and the walk starts at index 1.
REQ-005 Port clock  input  1  the single clock; all state updates on its rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-008 Port abort  input  1  terminates an in-progress dump.
REQ-009 Port rf_read_addr  output  ADDR_WIDTH  register-file read-port address.
REQ-010 Port rf_read_data  input  DATA_WIDTH  register-file read data, combinational from rf_read_addr.
REQ-011 Port dump_valid  output  1  dump_index/dump_data hold a valid entry.
REQ-012 Port dump_ready  input  1  consumer accepts the current entry.
REQ-013 Port dump_index  output  ADDR_WIDTH  index of the presented entry.
REQ-014 Port dump_data  output  DATA_WIDTH  value of the presented entry.
REQ-015 Port busy  output  1  high in every state except IDLE.
REQ-016 Port done  output  1  one-cycle pulse when the last entry is accepted.

Function
REQ-017 The FSM SHALL have states IDLE, READ, SEND and FINISH.
- IDLE->READ on start.
- READ->SEND unconditionally.
- SEND->READ on handshake when the index is not last.
- SEND->FINISH on handshake when the index is last.
- FINISH->IDLE unconditionally.
REQ-018 In IDLE with start=1, the index counter SHALL load SKIP_ZERO ? 1 : 0.
REQ-019 rf_read_addr SHALL equal the index counter in every state.
REQ-020 In READ, rf_read_data SHALL be registered into dump_data, and the counter into dump_index, at the clock edge leaving READ.
REQ-021 dump_valid SHALL be 1 exactly in SEND; dump_index/dump_data SHALL stay stable while dump_valid=1 and dump_ready=0.
REQ-022 A handshake SHALL occur on a rising edge with dump_valid=1 and dump_ready=1.
REQ-023 Each non-last handshake SHALL increment the counter by 1; the counter SHALL never exceed NUM_REGS-1 (no wrap).
REQ-024 Latency:
- first dump_valid SHALL assert 2 cycles after the start cycle;
- with dump_ready tied high, each entry SHALL take exactly 2 cycles.
REQ-025 done SHALL be 1 only in FINISH, for exactly one cycle.
REQ-026 start asserted outside IDLE SHALL be ignored.
REQ-027 abort=1 in READ, SEND or FINISH SHALL force IDLE on the next edge, clear dump_valid, and never produce done; abort SHALL take priority over a simultaneous handshake.
REQ-028 abort=1 in IDLE SHALL have no effect and SHALL take priority over start.

Reset
REQ-029 While reset=1, independent of clock: state SHALL be IDLE; counter, rf_read_addr, dump_index and dump_data SHALL be 0; dump_valid, busy and done SHALL be 0.
REQ-030 Reset asserted mid-dump SHALL discard the dump; no done pulse SHALL follow deassertion.

Structure
REQ-031 The state enumeration and the default NUM_REGS/ADDR_WIDTH/DATA_WIDTH constants SHALL live in the shared package reg_dump_pkg.
REQ-032 The block SHALL be a single module with no sub-module; the counter and FSM SHALL be inline.

Verification
REQ-033 RF loaded with x[i]=i*3, SKIP_ZERO=1, dump_ready=1, start pulse -> 31 entries, index 1..31, data 3..93, one entry every 2 cycles, done 1 cycle after index 31 is accepted.
REQ-034 SKIP_ZERO=0, same RF -> 32 entries starting with index 0 / data 0; done pulses once.
REQ-035 dump_ready held low for 5 cycles on index 4 -> dump_valid stays 1 and index 4 / data 12 stay stable; the walk resumes with index 5.
REQ-036 abort raised in SEND at index 10 with dump_ready=1 -> dump_valid=0 and busy=0 next cycle; no done; a subsequent start restarts at index 1.
REQ-037 start pulsed again during a dump -> entry sequence unchanged, a single done.
REQ-038 reset asserted asynchronously between edges mid-dump -> all outputs 0 immediately; after release, IDLE with no done and no dump_valid.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-file dump walker: FSM state encoding
// and the default geometry of the register file being walked.
package reg_dump_pkg;

    localparam int DEFAULT_NUM_REGS   = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_SEND   = 2'd2,
        ST_FINISH = 2'd3
    } dump_state_t;

endpackage : reg_dump_pkg

// File: rtl/reg_dump_unit.sv
// Walks a register file one entry at a time and presents each index/value
// pair on a valid/ready stream; pulses done after the last entry is taken.
module reg_dump_unit
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS   = DEFAULT_NUM_REGS,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SKIP_ZERO  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rf_read_addr,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_WIDTH-1:0] dump_index,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = (SKIP_ZERO != 0) ? ADDR_WIDTH'(1) : '0;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);

    dump_state_t           state;
    dump_state_t           next_state;
    logic [ADDR_WIDTH-1:0] index;
    logic                  load_index;
    logic                  advance_index;
    logic                  capture;
    logic                  handshake;
    logic                  at_last;

    assign at_last    = (index == LAST_IDX);
    assign handshake  = dump_valid && dump_ready;

    // Outputs decode directly from state so reset clears them without a clock.
    assign rf_read_addr = index;
    assign dump_valid   = (state == ST_SEND);
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_FINISH);

    always_comb begin
        next_state    = state;
        load_index    = 1'b0;
        advance_index = 1'b0;
        capture       = 1'b0;
        case (state)
            ST_IDLE: begin
                // abort outranks start even while idle
                if (start && !abort) begin
                    next_state = ST_READ;
                    load_index = 1'b1;
                end
            end
            ST_READ: begin
                if (abort) begin
                    next_state = ST_IDLE;
                end else begin
                    next_state = ST_SEND;
                    capture    = 1'b1;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    next_state = ST_IDLE;
                end else if (handshake) begin
                    if (at_last) begin
                        next_state = ST_FINISH;
                    end else begin
                        next_state    = ST_READ;
                        advance_index = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            index      <= '0;
            dump_index <= '0;
            dump_data  <= '0;
        end else begin
            state <= next_state;
            if (load_index) begin
                index <= FIRST_IDX;
            end else if (advance_index) begin
                index <= index + ADDR_WIDTH'(1);
            end
            // The read port is combinational, so the entry is latched as READ exits.
            if (capture) begin
                dump_index <= index;
                dump_data  <= rf_read_data;
            end
        end
    end

endmodule : reg_dump_unit

// File: tb/tb_reg_dump_unit.sv
// Scoreboard bench for reg_dump_unit: two instances (index 0 skipped / not
// skipped) read a register file modelled as x[i] = i*3.
module tb_reg_dump_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b1;
    logic [4:0]  addr_a, index_a;
    logic [31:0] rdata_a, data_a;
    logic        valid_a, busy_a, done_a;

    logic        start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b1;
    logic [4:0]  addr_b, index_b;
    logic [31:0] rdata_b, data_b;
    logic        valid_b, busy_b, done_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int prev_hs_a = 0;
    bit have_prev_a = 0;
    bit gap_en_a = 0;

    logic [4:0] qa [$];
    logic [4:0] qb [$];

    assign rdata_a = 32'(addr_a) * 32'd3;
    assign rdata_b = 32'(addr_b) * 32'd3;

    reg_dump_unit #(.NUM_REGS(32), .ADDR_WIDTH(5), .DATA_WIDTH(32), .SKIP_ZERO(1)) dut_a (
        .clock(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .rf_read_addr(addr_a), .rf_read_data(rdata_a),
        .dump_valid(valid_a), .dump_ready(ready_a),
        .dump_index(index_a), .dump_data(data_a),
        .busy(busy_a), .done(done_a)
    );

    reg_dump_unit #(.NUM_REGS(32), .ADDR_WIDTH(5), .DATA_WIDTH(32), .SKIP_ZERO(0)) dut_b (
        .clock(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .rf_read_addr(addr_b), .rf_read_data(rdata_b),
        .dump_valid(valid_b), .dump_ready(ready_b),
        .dump_index(index_b), .dump_data(data_b),
        .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_range(input int lo, input int hi, input bit to_b);
        for (int i = lo; i <= hi; i++) begin
            if (to_b) qb.push_back(5'(i));
            else      qa.push_back(5'(i));
        end
    endtask

    // Handshakes are sampled mid-cycle; they complete on the following rising edge.
    always @(negedge clk) begin
        logic [4:0] e;
        if (!reset && valid_a && ready_a && !abort_a) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_entry", 64'(index_a), 64'd99);
            end else begin
                e = qa.pop_front();
                chk("a_index", 64'(index_a), 64'(e));
                chk("a_data", 64'(data_a), 64'(32'(e) * 32'd3));
            end
            if (gap_en_a && have_prev_a) chk("a_entry_gap", 64'(cyc - prev_hs_a), 64'd2);
            prev_hs_a   = cyc;
            have_prev_a = 1'b1;
        end
        if (!reset && valid_b && ready_b && !abort_b) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_entry", 64'(index_b), 64'd99);
            end else begin
                e = qb.pop_front();
                chk("b_index", 64'(index_b), 64'(e));
                chk("b_data", 64'(data_b), 64'(32'(e) * 32'd3));
            end
        end
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(input string name);
        int n = 0;
        while (!done_a && n < 300) begin step(); n++; end
        chk({name, "_done_seen"}, 64'(done_a), 64'd1);
        chk({name, "_done_valid_low"}, 64'(valid_a), 64'd0);
        step();
        chk({name, "_done_one_cycle"}, 64'(done_a), 64'd0);
        chk({name, "_idle_after_done"}, 64'(busy_a), 64'd0);
    endtask

    task automatic wait_entry_a(input int idx, input string name);
        int n = 0;
        while (!(valid_a && index_a == 5'(idx)) && n < 300) begin step(); n++; end
        chk({name, "_reached"}, 64'(index_a), 64'(idx));
    endtask

    initial begin
        int base;
        // Reset state
        #3;
        chk("rst_valid", 64'(valid_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_addr", 64'(addr_a), 64'd0);
        chk("rst_index", 64'(index_a), 64'd0);
        chk("rst_data", 64'(data_a), 64'd0);
        chk("rst_b_busy", 64'(busy_b), 64'd0);
        step(); step();
        reset = 1'b0;
        step();

        // Full walk with index 0 skipped, ready tied high
        push_range(1, 31, 0);
        gap_en_a = 1; have_prev_a = 0;
        start_a = 1;
        step();
        start_a = 0;
        chk("lat_busy", 64'(busy_a), 64'd1);
        chk("lat_valid_early", 64'(valid_a), 64'd0);
        chk("lat_addr_first", 64'(addr_a), 64'd1);
        step();
        chk("lat_valid_2cyc", 64'(valid_a), 64'd1);
        wait_done_a("walk1");
        gap_en_a = 0;
        chk("walk1_queue_empty", 64'(qa.size()), 64'd0);
        chk("walk1_done_count", 64'(done_cnt_a), 64'd1);

        // Full walk including index 0
        push_range(0, 31, 1);
        start_b = 1;
        step();
        start_b = 0;
        chk("walkb_addr_first", 64'(addr_b), 64'd0);
        for (int n = 0; n < 300 && !done_b; n++) step();
        chk("walkb_done_seen", 64'(done_b), 64'd1);
        step();
        chk("walkb_queue_empty", 64'(qb.size()), 64'd0);
        chk("walkb_done_count", 64'(done_cnt_b), 64'd1);

        // Backpressure on index 4
        push_range(1, 31, 0);
        start_a = 1; step(); start_a = 0;
        wait_entry_a(4, "bp");
        ready_a = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_valid_held", 64'(valid_a), 64'd1);
            chk("bp_index_held", 64'(index_a), 64'd4);
            chk("bp_data_held", 64'(data_a), 64'd12);
        end
        ready_a = 1;
        step(); step();
        chk("bp_resume_index", 64'(index_a), 64'd5);
        wait_done_a("bp");
        chk("bp_queue_empty", 64'(qa.size()), 64'd0);
        chk("bp_done_count", 64'(done_cnt_a), 64'd2);

        // Abort in SEND at index 10 with ready high
        push_range(1, 9, 0);
        start_a = 1; step(); start_a = 0;
        wait_entry_a(10, "abort");
        abort_a = 1;
        step();
        abort_a = 0;
        chk("abort_valid", 64'(valid_a), 64'd0);
        chk("abort_busy", 64'(busy_a), 64'd0);
        for (int k = 0; k < 4; k++) step();
        chk("abort_no_done", 64'(done_cnt_a), 64'd2);
        chk("abort_queue_empty", 64'(qa.size()), 64'd0);
        push_range(1, 31, 0);
        start_a = 1; step(); start_a = 0;
        step();
        chk("restart_index", 64'(index_a), 64'd1);
        wait_done_a("restart");
        chk("restart_done_count", 64'(done_cnt_a), 64'd3);

        // Abort takes priority over start in IDLE
        abort_a = 1; start_a = 1; step(); abort_a = 0; start_a = 0;
        chk("idle_abort_start", 64'(busy_a), 64'd0);

        // Extra start pulses during a dump are ignored
        push_range(1, 31, 0);
        start_a = 1; step(); start_a = 0;
        for (int k = 0; k < 9; k++) step();
        start_a = 1; step(); start_a = 0;
        step();
        start_a = 1; step(); start_a = 0;
        wait_done_a("restart_ign");
        for (int k = 0; k < 4; k++) step();
        chk("restart_ign_idle", 64'(busy_a), 64'd0);
        chk("restart_ign_queue", 64'(qa.size()), 64'd0);
        chk("restart_ign_done_count", 64'(done_cnt_a), 64'd4);

        // Asynchronous reset mid-dump
        base = done_cnt_a;
        push_range(1, 5, 0);
        start_a = 1; step(); start_a = 0;
        wait_entry_a(6, "areset");
        ready_a = 0;
        #2;
        reset = 1;
        #1;
        chk("areset_valid", 64'(valid_a), 64'd0);
        chk("areset_busy", 64'(busy_a), 64'd0);
        chk("areset_done", 64'(done_a), 64'd0);
        chk("areset_addr", 64'(addr_a), 64'd0);
        chk("areset_index", 64'(index_a), 64'd0);
        chk("areset_data", 64'(data_a), 64'd0);
        step();
        #2;
        reset = 0;
        ready_a = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("areset_post_valid", 64'(valid_a), 64'd0);
        end
        chk("areset_post_busy", 64'(busy_a), 64'd0);
        chk("areset_no_done", 64'(done_cnt_a), 64'(base));
        chk("areset_queue_empty", 64'(qa.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_dump_unit
